serial_adder: RTL and testbench

- Bit-serial N-bit adder, one bit position per clock, LSB first.
- Built on the existing half_adder cell: two half_adder instances plus an OR form the per-bit full adder.
- A registered carry links successive bit slices.
- Operand intake and result delivery use valid/ready handshakes; the block sits between an operand source and a result consumer.

---
 rtl/serial_adder_pkg.sv | 25 ++
 rtl/half_adder.sv | 18 +
 rtl/serial_adder_full_adder_bit.sv | 38 +++
 rtl/serial_adder.sv | 135 +++++++++++++
 tb/tb_serial_adder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_pkg
//  Purpose  : Shared types and helpers for the bit-serial adder.
//             Used by serial_adder; optional subtract mode is enabled by
//             defining SERIAL_ADDER_SUB_EN.
//  Revision : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Width of the bit-position counter; it counts 0 .. width-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
//  Module   : half_adder
//  Purpose  : Single-bit half adder cell.
//  Revision : 1.0  initial release
// ============================================================================
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule : half_adder
`default_nettype wire

// File: rtl/serial_adder_full_adder_bit.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder_bit
//  Purpose  : Combinational one-bit full adder built from two half adders
//             and an OR gate joining their carries.
//  Revision : 1.0  initial release
// ============================================================================
module full_adder_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic w_ab_sum;
    logic w_ab_carry;
    logic w_cin_carry;

    half_adder u_ha_ab (
        .a_i     (a_i),
        .b_i     (b_i),
        .sum_o   (w_ab_sum),
        .carry_o (w_ab_carry)
    );

    half_adder u_ha_cin (
        .a_i     (w_ab_sum),
        .b_i     (cin_i),
        .sum_o   (sum_o),
        .carry_o (w_cin_carry)
    );

    // Both half adders can never carry at once, so OR is sufficient.
    assign cout_o = w_ab_carry | w_cin_carry;

endmodule : full_adder_bit
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder, LSB first, one bit per clock, with
//             valid/ready handshakes on operand intake and result delivery.
//             Define SERIAL_ADDER_SUB_EN to add the op_sub_i port and the
//             A - B mode (B inverted, carry-in of 1).
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             op_sub_i,
`endif
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sh_q, sh_d;     // partial sum being assembled
    logic [WIDTH-1:0]   sum_q, sum_d;   // last completed result
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               w_sub;
    logic               w_bit_sum;
    logic               w_bit_cout;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = op_sub_i;
`else
    assign w_sub = 1'b0;
`endif

    full_adder_bit u_fa (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .sum_o  (w_bit_sum),
        .cout_o (w_bit_cout)
    );

    // State and datapath registers; async reset discards any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update: load on accept, shift one bit per cycle,
    // publish the result on the final bit, then wait for the consumer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = w_sub ? ~b_i : b_i;
                    carry_d = w_sub;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                sh_d    = {w_bit_sum, sh_q[WIDTH-1:1]};
                carry_d = w_bit_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {w_bit_sum, sh_q[WIDTH-1:1]};
                    cout_d  = w_bit_cout;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Scoreboard bench for serial_adder (WIDTH=8). Define
//             SERIAL_ADDER_SUB_EN to also exercise the subtract mode.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         sub       = 1'b0;
    logic         in_ready_o;
    logic         out_valid_o;
    logic [W-1:0] sum_o;
    logic         cout_o;

    int           checks = 0;
    int           errors = 0;
    logic [W:0]   exp_q[$];
    int           hs_cnt  = 0;
    int           exp_hs  = 0;
    int           cyc     = 0;
    int           acc_cyc = 0;
    logic         prev_valid = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
`ifdef SERIAL_ADDER_SUB_EN
        .op_sub_i    (sub),
`endif
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .sum_o       (sum_o),
        .cout_o      (cout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, checks latency, holds and results.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (in_valid && in_ready_o)
                acc_cyc = cyc + 1;
            if (out_valid_o) begin
                if (!prev_valid)
                    chk("latency", cyc - acc_cyc, W);
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {23'd0, cout_o, sum_o}, 32'hFFFF_FFFF);
                end else if (out_ready) begin
                    chk("result", {23'd0, cout_o, sum_o}, {23'd0, exp_q.pop_front()});
                    hs_cnt++;
                end else begin
                    chk("hold", {23'd0, cout_o, sum_o}, {23'd0, exp_q[0]});
                end
            end
            prev_valid = out_valid_o;
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic ts, input logic [W-1:0] es, input logic ec);
        int n = 0;
        while (!in_ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready_o) chk("ready_timeout", 32'd0, 32'd1);
        a        = ta;
        b        = tb;
        sub      = ts;
        in_valid = 1'b1;
        exp_q.push_back({ec, es});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_hs();
        exp_hs++;
        for (int n = 0; n < 200 && hs_cnt < exp_hs; n++)
            @(posedge clk);
        #1;
        chk("handshake_count", hs_cnt, exp_hs);
    endtask

    initial begin
        int seen;

        // Reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready", {31'd0, in_ready_o}, 1);
        chk("rst_out_valid", {31'd0, out_valid_o}, 0);
        chk("rst_sum", {24'd0, sum_o}, 0);
        chk("rst_cout", {31'd0, cout_o}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Basic add and carry ripple
        issue(8'h05, 8'h03, 1'b0, 8'h08, 1'b0); wait_hs();
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1); wait_hs();
        issue(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1); wait_hs();

        // Back-pressure
        out_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        for (int n = 0; n < 50 && !out_valid_o; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid_seen", {31'd0, out_valid_o}, 1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {31'd0, in_ready_o}, 0);
            chk("bp_valid_held", {31'd0, out_valid_o}, 1);
        end
        out_ready = 1'b1;
        exp_hs++;
        @(posedge clk); #1;
        chk("bp_valid_drop", {31'd0, out_valid_o}, 0);
        chk("bp_in_ready_back", {31'd0, in_ready_o}, 1);
        chk("bp_single_hs", hs_cnt, exp_hs);

        // Busy rejection
        issue(8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
        a = 8'hAA; b = 8'h55; in_valid = 1'b1;
        repeat (3) begin
            chk("busy_in_ready", {31'd0, in_ready_o}, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_hs();
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("busy_no_extra", {31'd0, out_valid_o}, 0);
        chk("busy_queue_empty", exp_q.size(), 0);

        // Reset mid-operation
        issue(8'h77, 8'h11, 1'b0, 8'h88, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready_o}, 1);
        chk("mid_rst_out_valid", {31'd0, out_valid_o}, 0);
        chk("mid_rst_sum", {24'd0, sum_o}, 0);
        chk("mid_rst_cout", {31'd0, cout_o}, 0);
        exp_q.delete();
        #2 rst = 1'b0;
        seen = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (out_valid_o) seen++;
        end
        chk("no_valid_after_reset", seen, 0);
        issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0); wait_hs();

`ifdef SERIAL_ADDER_SUB_EN
        // Subtract mode
        issue(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0); wait_hs();
        issue(8'h07, 8'h05, 1'b1, 8'h02, 1'b1); wait_hs();
        issue(8'h07, 8'h05, 1'b0, 8'h0C, 1'b0); wait_hs();
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
